// File: rtl/ex_hazard_sequencer_if.sv
// Hazard-control bundle between the pipeline datapath and the EX sequencer.
// The sequencer takes the slave side; the datapath drives the master side.
interface ex_hazard_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic [REG_W-1:0]  IF_ID_rs1;
  logic [REG_W-1:0]  IF_ID_rs2;
  logic [REG_W-1:0]  ID_EX_rd;
  logic              ID_EX_MemRead;
  logic              old_branch;
  logic              branch_result;
  logic              old_predict;
  logic [DATA_W-1:0] old_pc;
  logic              md_op;
  logic              md_done;
  logic              mem_busy;
  logic              md_go;
  logic              pc_stall;
  logic              IF_ID_stall;
  logic              IF_ID_flush;
  logic              ID_EX_stall;
  logic              ID_EX_flush;
  logic              EX_MEM_stall;
  logic              EX_MEM_flush;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, ID_EX_rd,
    output ID_EX_MemRead, old_branch,
    output branch_result, old_predict,
    output old_pc, md_op, md_done, mem_busy,
    input  md_go, pc_stall,
    input  IF_ID_stall, IF_ID_flush,
    input  ID_EX_stall, ID_EX_flush,
    input  EX_MEM_stall, EX_MEM_flush,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd,
    input  ID_EX_MemRead, old_branch,
    input  branch_result, old_predict,
    input  old_pc, md_op, md_done, mem_busy,
    output md_go, pc_stall,
    output IF_ID_stall, IF_ID_flush,
    output ID_EX_stall, ID_EX_flush,
    output EX_MEM_stall, EX_MEM_flush,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_hazard_sequencer.sv
// EX-stage hazard sequencer: load-use, mispredict, MUL/DIV and mem waits.
// Optional perf counters enabled by macro HAZARD_PERF_CNT_EN.
module ex_hazard_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic clk,
  input  logic rst,
  ex_hazard_sequencer_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_loaduse,
  output logic [31:0] perf_mispredict,
  output logic [31:0] perf_md_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN,
    MD_BUSY,
    MD_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_done;
  logic   w_done_nxt;

  logic [REG_W-1:0]  w_rd;
  logic [DATA_W-1:0] w_pc;
  logic              w_mispredict;
  logic              w_loaduse;
  logic              w_lu_fire;

  assign w_rd = bus.ID_EX_rd;
  assign w_pc = bus.old_pc;

  assign w_mispredict = bus.old_branch &
    (bus.branch_result != bus.old_predict);

  assign w_loaduse = bus.ID_EX_MemRead &
    (w_rd != '0) &
    ((w_rd == bus.IF_ID_rs1) |
     (w_rd == bus.IF_ID_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_done_nxt         = r_done;
    w_lu_fire          = 1'b0;
    bus.md_go          = 1'b0;
    bus.pc_stall       = 1'b0;
    bus.IF_ID_stall    = 1'b0;
    bus.IF_ID_flush    = 1'b0;
    bus.ID_EX_stall    = 1'b0;
    bus.ID_EX_flush    = 1'b0;
    bus.EX_MEM_stall   = 1'b0;
    bus.EX_MEM_flush   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    // Outputs are forced low for the whole time rst is held.
    if (!rst) begin
      if (bus.mem_busy) begin
        bus.pc_stall     = 1'b1;
        bus.IF_ID_stall  = 1'b1;
        bus.ID_EX_stall  = 1'b1;
        bus.EX_MEM_stall = 1'b1;
        if (r_state == MD_BUSY && bus.md_done)
          w_done_nxt = 1'b1;
      end else if (r_state == MD_BUSY) begin
        bus.pc_stall     = 1'b1;
        bus.IF_ID_stall  = 1'b1;
        bus.ID_EX_stall  = 1'b1;
        bus.EX_MEM_flush = 1'b1;
        if (bus.md_done || r_done) begin
          w_state_nxt = MD_DONE;
          w_done_nxt  = 1'b0;
        end
      end else if (w_mispredict) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = w_pc;
        bus.IF_ID_flush    = 1'b1;
        bus.ID_EX_flush    = 1'b1;
        w_state_nxt        = RUN;
      end else if (r_state == RUN && bus.md_op) begin
        bus.md_go        = 1'b1;
        bus.pc_stall     = 1'b1;
        bus.IF_ID_stall  = 1'b1;
        bus.ID_EX_stall  = 1'b1;
        bus.EX_MEM_flush = 1'b1;
        w_state_nxt      = MD_BUSY;
      end else begin
        if (w_loaduse) begin
          w_lu_fire       = 1'b1;
          bus.pc_stall    = 1'b1;
          bus.IF_ID_stall = 1'b1;
          bus.ID_EX_flush = 1'b1;
        end
        w_state_nxt = RUN;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic w_md_cnt;

  assign w_md_cnt = (r_state == MD_BUSY) | bus.md_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loaduse    <= '0;
      perf_mispredict <= '0;
      perf_md_cycles  <= '0;
    end else begin
      if (w_lu_fire)
        perf_loaduse <= perf_loaduse + 32'd1;
      if (bus.redirect_valid)
        perf_mispredict <= perf_mispredict + 32'd1;
      if (w_md_cnt)
        perf_md_cycles <= perf_md_cycles + 32'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_lu_fire;
`endif

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Directed bench for ex_hazard_sequencer.
// Control outputs are packed into one vector and compared per cycle.
module tb_ex_hazard_sequencer;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // {md_go, pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, rv}
  localparam logic [8:0] NONE = 9'b0_0000_0000;
  localparam logic [8:0] LU   = 9'b0_1100_0100;
  localparam logic [8:0] MP   = 9'b0_0000_1101;
  localparam logic [8:0] MDB  = 9'b0_1110_0010;
  localparam logic [8:0] MDGO = 9'b1_1110_0010;
  localparam logic [8:0] FRZ  = 9'b0_1111_0000;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  ex_hazard_sequencer_if #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_loaduse;
  logic [31:0] perf_mispredict;
  logic [31:0] perf_md_cycles;
`endif

  ex_hazard_sequencer #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_loaduse   (perf_loaduse),
    .perf_mispredict(perf_mispredict),
    .perf_md_cycles (perf_md_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] ctl;
  assign ctl = {bus.md_go, bus.pc_stall,
    bus.IF_ID_stall, bus.ID_EX_stall,
    bus.EX_MEM_stall, bus.IF_ID_flush,
    bus.ID_EX_flush, bus.EX_MEM_flush,
    bus.redirect_valid};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.IF_ID_rs1     = '0;
    bus.IF_ID_rs2     = '0;
    bus.ID_EX_rd      = '0;
    bus.ID_EX_MemRead = 1'b0;
    bus.old_branch    = 1'b0;
    bus.branch_result = 1'b0;
    bus.old_predict   = 1'b0;
    bus.old_pc        = '0;
    bus.md_op         = 1'b0;
    bus.md_done       = 1'b0;
    bus.mem_busy      = 1'b0;
  endtask

  // Check this cycle's outputs mid-cycle, then step past the next edge.
  task automatic step(input string tag,
                      input logic [8:0] ce,
                      input logic [31:0] pe);
    @(negedge clk);
    chk({tag, ".ctl"}, 64'(ctl), 64'(ce));
    chk({tag, ".pc"}, 64'(bus.redirect_pc), 64'(pe));
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2);
    bus.ID_EX_MemRead = 1'b1;
    bus.ID_EX_rd      = rd;
    bus.IF_ID_rs1     = rs1;
    bus.IF_ID_rs2     = rs2;
  endtask

  task automatic set_mp(input logic [31:0] pc);
    bus.old_branch    = 1'b1;
    bus.branch_result = 1'b1;
    bus.old_predict   = 1'b0;
    bus.old_pc        = pc;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    bus.md_op    = 1'b1;
    bus.mem_busy = 1'b1;
    set_mp(32'h0000_0040);
    step("rst_hold", NONE, 32'h0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("idle", NONE, 32'h0);

    set_lu(5'd5, 5'd1, 5'd5);
    step("lu_rs2", LU, 32'h0);
    bus.ID_EX_MemRead = 1'b0;
    step("lu_bubble", NONE, 32'h0);
    set_lu(5'd7, 5'd7, 5'd2);
    step("lu_rs1", LU, 32'h0);
    set_lu(5'd0, 5'd0, 5'd0);
    step("lu_x0", NONE, 32'h0);
    idle();

    set_mp(32'h0000_0040);
    step("mp", MP, 32'h40);
    idle();
    step("mp_after", NONE, 32'h0);
    set_mp(32'h0000_0080);
    bus.old_predict = 1'b1;
    step("mp_match", NONE, 32'h0);
    idle();

    set_mp(32'h0000_1234);
    set_lu(5'd3, 5'd3, 5'd3);
    step("mp_lu", MP, 32'h1234);
    bus.mem_busy = 1'b1;
    step("mp_lu_busy", FRZ, 32'h0);
    idle();

    bus.md_op = 1'b1;
    step("md_c0", MDGO, 32'h0);
    step("md_c1", MDB, 32'h0);
    step("md_c2", MDB, 32'h0);
    step("md_c3", MDB, 32'h0);
    bus.md_done = 1'b1;
    step("md_c4", MDB, 32'h0);
    bus.md_done = 1'b0;
    step("md_c5", NONE, 32'h0);
    step("md_c6_run", MDGO, 32'h0);
    bus.md_done = 1'b1;
    step("md2_done", MDB, 32'h0);
    bus.md_done = 1'b0;
    set_lu(5'd9, 5'd9, 5'd0);
    step("md2_lu", LU, 32'h0);
    idle();
    step("md2_run", NONE, 32'h0);

    bus.md_op = 1'b1;
    step("mb_go", MDGO, 32'h0);
    step("mb_busy", MDB, 32'h0);
    bus.mem_busy = 1'b1;
    bus.md_done  = 1'b1;
    step("mb_frz1", FRZ, 32'h0);
    bus.md_done = 1'b0;
    step("mb_frz2", FRZ, 32'h0);
    bus.mem_busy = 1'b0;
    step("mb_latched", MDB, 32'h0);
    step("mb_mddone", NONE, 32'h0);
    idle();
    step("mb_run", NONE, 32'h0);

    bus.md_op = 1'b1;
    step("rs_go", MDGO, 32'h0);
    @(negedge clk);
    chk("rs_busy", 64'(ctl), 64'(MDB));
    rst = 1'b1;
    #1;
    chk("rs_async", 64'(ctl), 64'(NONE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.md_op = 1'b0;
    step("rs_run1", NONE, 32'h0);
    step("rs_run2", NONE, 32'h0);
    bus.md_op = 1'b1;
    step("rs_go2", MDGO, 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_hazard_sequencer.md
Name: ex_hazard_sequencer

Overview:
- Pipeline-control block for the 5-stage core. It sequences the EX stage and the stage registers around it.
- Resolves load-use stalls, branch/jump mispredict flushes, multi-cycle MUL/DIV occupancy of EX, and data-memory wait states.
- Drives per-stage stall/flush enables, the PC redirect, and the MUL/DIV start pulse.
- Combinational outputs are decoded from a registered FSM plus current-cycle hazard inputs.

Parameters:
DATA_W, 32, PC/data width
REG_W, 5, register index width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
IF_ID_rs1  in  REG_W  rs1 of instruction in ID
IF_ID_rs2  in  REG_W  rs2 of instruction in ID
ID_EX_rd  in  REG_W  rd of instruction in EX
ID_EX_MemRead  in  1  EX instruction is a load
old_branch  in  1  EX instruction is branch/jal/jalr
branch_result  in  1  resolved taken
old_predict  in  1  predicted taken
old_pc  in  DATA_W  correct next PC from BRU
md_op  in  1  EX instruction is MUL/DIV
md_done  in  1  MUL/DIV unit result valid (1-cycle pulse)
mem_busy  in  1  data memory/MMIO not ready this cycle
md_go  out  1  start pulse to MUL/DIV unit
pc_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID register
IF_ID_flush  out  1  bubble IF/ID register
ID_EX_stall  out  1  hold ID/EX register
ID_EX_flush  out  1  bubble ID/EX register
EX_MEM_stall  out  1  hold EX/MEM register
EX_MEM_flush  out  1  bubble EX/MEM register
redirect_valid  out  1  load PC from redirect_pc
redirect_pc  out  DATA_W  redirect target

Behaviour:
- States: RUN, MD_BUSY, MD_DONE. Reset: state=RUN, done_latched=0. While rst is high, every output is 0 and redirect_pc=0.
- Priority, highest first: mem_busy, MD_BUSY, mispredict, md launch, load-use.
- mem_busy=1 in any state:
  - pc/IF_ID/ID_EX/EX_MEM stall all =1; every flush, redirect_valid and md_go =0.
  - The state does not advance.
  - md_done seen in MD_BUSY sets done_latched.
- MD_BUSY, mem_busy=0:
  - pc/IF_ID/ID_EX stall =1; EX_MEM_flush=1.
  - Go to MD_DONE when md_done=1 or done_latched=1; clear done_latched on that transition.
- MD_DONE, mem_busy=0:
  - The EX instruction advances into EX/MEM; md_op is ignored.
  - Load-use rule still applies. Next state is RUN.
- RUN, md_op=1, mem_busy=0:
  - md_go=1 for exactly this cycle.
  - Stall/flush outputs are the same as in MD_BUSY. Next state is MD_BUSY.
- Mispredict = old_branch & (branch_result != old_predict). It is evaluated in RUN and MD_DONE only, with mem_busy=0.
  - On mispredict: redirect_valid=1, redirect_pc=old_pc, IF_ID_flush=1, ID_EX_flush=1, no stalls.
  - Mispredict overrides load-use in the same cycle.
- Load-use: ID_EX_MemRead & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2).
  - Response: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1 for one cycle.
  - The bubble clears the condition the next cycle.
- A stall and a flush on the same register never assert together. Flush wins only where stated above.
- Whenever redirect_valid=0, redirect_pc=0.
- Latency:
  - Mispredict penalty: 2 cycles.
  - Load-use penalty: 1 cycle.
  - MUL/DIV occupancy: (cycles until md_done)+1, plus any mem_busy cycles.
- Asserting rst mid-MD_BUSY returns to RUN immediately. The MUL/DIV unit is reset by the same rst.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Enabled: adds three 32-bit outputs, perf_loaduse, perf_mispredict, perf_md_cycles.
  - perf_loaduse counts cycles in which load-use stall fires.
  - perf_mispredict counts cycles with redirect_valid=1.
  - perf_md_cycles counts cycles in MD_BUSY plus the md_go cycle.
  - All counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- Disabled: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5 -> one cycle of pc_stall=IF_ID_stall=ID_EX_flush=1. Same case with ID_EX_rd=0 -> no stall.
- Mispredict: old_branch=1, branch_result=1, old_predict=0, old_pc=0x0000_0040 -> redirect_valid=1, redirect_pc=0x40, IF_ID_flush=ID_EX_flush=1 for 1 cycle. Matching prediction -> no redirect.
- MUL/DIV: md_op=1 in RUN -> md_go pulse in cycle 0, stalls held; md_done in cycle 4 -> MD_DONE in cycle 5 with no stalls and md_go=0; RUN in cycle 6.
- md_done arriving while mem_busy=1 in MD_BUSY -> all stalls held. When mem_busy drops, the FSM enters MD_DONE with no second md_go.
- Simultaneous mispredict and load-use -> redirect and flushes only, no stall. With mem_busy=1 added -> full freeze, redirect_valid=0.
- rst asserted mid-MD_BUSY -> all outputs 0 asynchronously; after release, state is RUN and md_go=0 until the next md_op.
